// File: rtl/rcv_pkg.sv
// Shared types and helpers for the serial receiver.
package rcv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECV,
    STOP_CHK,
    WAIT_IDLE
  } state_t;

  // Offset from the start edge to the middle of the start bit.
  function automatic int calc_half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/flex_stp_sr.sv
// Serial-to-parallel shift register; direction selects which end the
// first received bit ends up at.
module flex_stp_sr #(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] parallel_out
);

  logic [NUM_BITS-1:0] sr_q;

  // Shift one bit in on each enable; '1 matches the idle line level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q <= '1;
    end else if (shift_enable) begin
      if (SHIFT_MSB != 0) sr_q <= {sr_q[NUM_BITS-2:0], serial_in};
      else                sr_q <= {serial_in, sr_q[NUM_BITS-1:1]};
    end
  end

  assign parallel_out = sr_q;

endmodule

// File: rtl/serial_rcv_block.sv
// Idle-high serial receiver: synchronise, find the start edge, sample each
// bit mid-period, check the stop bit and hand the word over with a
// ready/read handshake plus overrun and framing flags.
module serial_rcv_block #(
  parameter int NUM_DATA_BITS = 8,
  parameter int CLKS_PER_BIT  = 10,
  parameter int SHIFT_MSB     = 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     serial_in,
  input  logic                     data_read,
  output logic [NUM_DATA_BITS-1:0] rx_data,
  output logic                     data_ready,
  output logic                     overrun_error,
  output logic                     framing_error
);
  import rcv_pkg::*;

  localparam int HALF_BIT = calc_half_bit(CLKS_PER_BIT);
  localparam int TMR_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam int CNT_W    = $clog2(NUM_DATA_BITS) + 1;

  logic                     sync1_q, sync_q, prev_q;
  state_t                   state_q, state_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic                     start_edge, sample_pt;
  logic                     shift_en, load_good, bad_stop;
  logic [NUM_DATA_BITS-1:0] sr_out;
  logic [NUM_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                     ready_q, ready_d;
  logic                     ovr_q, ovr_d;
  logic                     fe_q, fe_d;

  // Two-flop synchroniser followed by a previous-sample flop for edge detect.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
    end
  end

  assign start_edge = (state_q == IDLE) && prev_q && !sync_q;

  // The start check lands mid start bit; later samples are one period apart.
  assign sample_pt = ((state_q == START_CHK) && (timer_q == TMR_W'(HALF_BIT - 1))) ||
                     (((state_q == RECV) || (state_q == STOP_CHK)) &&
                      (timer_q == TMR_W'(CLKS_PER_BIT - 1)));

  // State, timer and bit counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next-state logic; bit counter tracks data bits received in RECV.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE:      if (start_edge) state_d = START_CHK;
      START_CHK: if (sample_pt) begin
                   if (sync_q) begin
                     state_d = IDLE;
                   end else begin
                     state_d   = RECV;
                     bit_cnt_d = '0;
                   end
                 end
      RECV:      if (sample_pt) begin
                   if (bit_cnt_q == CNT_W'(NUM_DATA_BITS - 1)) state_d = STOP_CHK;
                   else bit_cnt_d = bit_cnt_q + 1'b1;
                 end
      STOP_CHK:  if (sample_pt) state_d = sync_q ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (sync_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Bit timer: parked at zero while idle, restarts at every sample point.
  always_comb begin
    timer_d = timer_q + 1'b1;
    if ((state_q == IDLE) || (state_q == WAIT_IDLE) || sample_pt) timer_d = '0;
  end

  // FSM output strobes for the datapath.
  always_comb begin
    shift_en  = (state_q == RECV) && sample_pt;
    load_good = (state_q == STOP_CHK) && sample_pt && sync_q;
    bad_stop  = (state_q == STOP_CHK) && sample_pt && !sync_q;
  end

  flex_stp_sr #(
    .NUM_BITS (NUM_DATA_BITS),
    .SHIFT_MSB(SHIFT_MSB)
  ) u_sr (
    .clk         (clk),
    .n_rst       (n_rst),
    .shift_enable(shift_en),
    .serial_in   (sync_q),
    .parallel_out(sr_out)
  );

  // Output word and flags; a read coincident with a load consumes the old word.
  always_comb begin
    rx_data_d = rx_data_q;
    ready_d   = ready_q;
    ovr_d     = ovr_q;
    fe_d      = fe_q;
    if (load_good) begin
      rx_data_d = sr_out;
      ready_d   = 1'b1;
      if (data_read)    ovr_d = 1'b0;
      else if (ready_q) ovr_d = 1'b1;
    end else if (data_read && ready_q) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (start_edge)    fe_d = 1'b0;
    else if (bad_stop) fe_d = 1'b1;
  end

  // Output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data_q <= '1;
      ready_q   <= 1'b0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      ovr_q     <= ovr_d;
      fe_q      <= fe_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = ready_q;
  assign overrun_error = ovr_q;
  assign framing_error = fe_q;

endmodule

// File: tb/tb_serial_rcv_block.sv
// Directed bench for serial_rcv_block: an MSB-first and an LSB-first
// receiver share one serial line.
module tb_serial_rcv_block;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       serial_in;
  logic       data_read;
  logic [7:0] rx0, rx1;
  logic       rdy0, ovr0, fe0;
  logic       rdy1, ovr1, fe1;

  int checks = 0;
  int errors = 0;

  logic rdy_before, rdy_after, fe_at_start;

  always #5 clk = ~clk;

  serial_rcv_block #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(CPB), .SHIFT_MSB(1)) dut_msb (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .data_read(data_read),
    .rx_data(rx0), .data_ready(rdy0), .overrun_error(ovr0), .framing_error(fe0)
  );

  serial_rcv_block #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(CPB), .SHIFT_MSB(0)) dut_lsb (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .data_read(data_read),
    .rx_data(rx1), .data_ready(rdy1), .overrun_error(ovr1), .framing_error(fe1)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    step(CPB);
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    step(n);
  endtask

  // Start bit, data MSB first on the line, stop bit; snapshots ready around
  // the cycle that follows the stop sample.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    fe_at_start = fe0;
    for (int k = 0; k < 8; k++) drive_bit(d[7-k]);
    serial_in = stop;
    step(7);
    rdy_before = rdy0;
    step(1);
    rdy_after = rdy0;
    step(2);
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    step(1);
    data_read = 1'b0;
  endtask

  initial begin
    n_rst     = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    step(3);
    @(negedge clk);
    check("rst_rx",  rx0,  8'hFF);
    check("rst_rdy", {7'd0, rdy0}, 8'd0);
    check("rst_ovr", {7'd0, ovr0}, 8'd0);
    check("rst_fe",  {7'd0, fe0},  8'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    idle(20);

    // Single good frame with latency check
    send_frame(8'hA5, 1'b1);
    idle(10);
    check("a5_rdy_before", {7'd0, rdy_before}, 8'd0);
    check("a5_rdy_after",  {7'd0, rdy_after},  8'd1);
    check("a5_rx",  rx0, 8'hA5);
    check("a5_ovr", {7'd0, ovr0}, 8'd0);
    check("a5_fe",  {7'd0, fe0},  8'd0);
    pulse_read();
    check("a5_read_rdy", {7'd0, rdy0}, 8'd0);
    idle(10);

    // Overrun: two frames without a read
    send_frame(8'h3C, 1'b1);
    idle(10);
    check("3c_rx",  rx0, 8'h3C);
    check("3c_ovr", {7'd0, ovr0}, 8'd0);
    send_frame(8'hC3, 1'b1);
    idle(10);
    check("c3_rx",  rx0, 8'hC3);
    check("c3_rdy", {7'd0, rdy0}, 8'd1);
    check("c3_ovr", {7'd0, ovr0}, 8'd1);
    pulse_read();
    check("c3_read_rdy", {7'd0, rdy0}, 8'd0);
    check("c3_read_ovr", {7'd0, ovr0}, 8'd0);
    idle(10);

    // Framing error, held-low line, then recovery
    send_frame(8'h5A, 1'b0);
    check("5a_fe",  {7'd0, fe0},  8'd1);
    check("5a_rx",  rx0, 8'hC3);
    check("5a_rdy", {7'd0, rdy0}, 8'd0);
    serial_in = 1'b0;
    step(30);
    check("break_fe",  {7'd0, fe0},  8'd1);
    check("break_rdy", {7'd0, rdy0}, 8'd0);
    check("break_rx",  rx0, 8'hC3);
    idle(20);
    send_frame(8'h81, 1'b1);
    idle(10);
    check("81_fe_at_edge", {7'd0, fe_at_start}, 8'd0);
    check("81_rx",  rx0, 8'h81);
    check("81_rdy", {7'd0, rdy0}, 8'd1);
    check("81_fe",  {7'd0, fe0},  8'd0);

    // Short glitch on the idle line is a false start
    serial_in = 1'b0;
    step(3);
    idle(30);
    check("glitch_rx",  rx0, 8'h81);
    check("glitch_rdy", {7'd0, rdy0}, 8'd1);
    check("glitch_ovr", {7'd0, ovr0}, 8'd0);
    check("glitch_fe",  {7'd0, fe0},  8'd0);
    pulse_read();
    idle(10);

    // Line bits 1,0,0,0,0,0,0,0 into both shift directions
    send_frame(8'h80, 1'b1);
    idle(10);
    check("dir_msb_rx", rx0, 8'h80);
    check("dir_lsb_rx", rx1, 8'h01);
    check("dir_lsb_rdy", {7'd0, rdy1}, 8'd1);
    pulse_read();
    idle(10);
    check("dir_read_rdy", {7'd0, rdy0}, 8'd0);

    // Reset during data bit 4 (line high there, no fresh edge afterwards)
    drive_bit(1'b0);
    for (int k = 0; k < 4; k++) drive_bit(1'b0);
    serial_in = 1'b1;
    step(3);
    n_rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rx",  rx0, 8'hFF);
    check("mid_rst_rx1", rx1, 8'hFF);
    check("mid_rst_rdy", {7'd0, rdy0}, 8'd0);
    check("mid_rst_fe",  {7'd0, fe0},  8'd0);
    @(posedge clk); #1;
    step(1);
    n_rst = 1'b1;
    idle(5 + 4 * CPB + 20);
    check("post_rst_rdy", {7'd0, rdy0}, 8'd0);
    check("post_rst_rx",  rx0, 8'hFF);
    send_frame(8'hFF, 1'b1);
    idle(10);
    check("ff_rx",  rx0, 8'hFF);
    check("ff_rdy", {7'd0, rdy0}, 8'd1);
    check("ff_fe",  {7'd0, fe0},  8'd0);
    pulse_read();
    idle(10);
    send_frame(8'h96, 1'b1);
    idle(10);
    check("96_msb_rx", rx0, 8'h96);
    check("96_lsb_rx", rx1, 8'h69);
    check("96_ovr",    {7'd0, ovr0}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
